cpu_multicycle_ctrl: RTL and testbench
======================================

Name: cpu_multicycle_ctrl

Overview:
Multi-cycle control unit for the 16-bit CPU, replacing the purely combinational opcode decode. It sequences fetch, decode, execute and memory phases over a shared instruction/data memory with a ready handshake. It resolves conditional branches from the N/Z flags and adds ld/st, call/callr, memory timeout and illegal-opcode handling. Write enables and PC enable are strobed only in the cycle that commits them.

Parameters:
OPCODE_W, 5, opcode width; opcode bits above [4:0] must be zero, otherwise the instruction is illegal
WB_SEL_W, 3, width of wb_src
TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready before bus error; 0 disables the timeout
HALT_ON_ILLEGAL, 1, 1 = illegal opcode halts; 0 = executed as a nop

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
run  in  1  leave IDLE and start fetching
opcode  in  OPCODE_W  opcode field of the instruction register
flag_n  in  1  registered N flag
flag_z  in  1  registered Z flag
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write enable
mem_sel  out  1  1 = instruction fetch, 0 = data access
ir_load  out  1  load the instruction register
pc_enable  out  1  PC update strobe
pc_src  out  1  0 = branch target, 1 = pc+2
br_src  out  1  0 = rd1, 1 = pc+offset
ext_sel  out  1  0 = imm8, 1 = imm11
alu_op  out  1  0 = add, 1 = sub
alu_src  out  1  0 = rd2, 1 = immediate
reg_write  out  1  register file write strobe
reg_dst  out  1  0 = Rx, 1 = R7
wb_src  out  WB_SEL_W  000 mem, 001 alu, 010 pc+2, 011 Ry, 100 imm8, 101 imm8-high
nz_write  out  1  update N/Z flags
halted  out  1  controller is in HALT
bus_error  out  1  sticky; a timeout occurred

Behaviour:
- Reset, applied asynchronously: state goes to IDLE and every output is 0, including mem_req, so any in-flight access is dropped. Outputs are 0 in IDLE.
- IDLE: wait until run=1, then go to FETCH.
- FETCH:
  - Drive mem_req=1, mem_sel=1, mem_we=0.
  - On mem_ready: ir_load=1 in that same cycle, then go to DECODE.
- DECODE (1 cycle): no strobes. Illegal opcode goes to HALT when HALT_ON_ILLEGAL=1. Otherwise pc_enable=1, pc_src=1, then FETCH.
- EXEC (1 cycle), by opcode:
  - ALU/move (mv 00000, add 00001, sub 00010, mvi 10000, addi 10001, subi 10010, mvhi 10110): reg_write=1, pc_enable=1, pc_src=1, then FETCH. nz_write=1 for add, sub, addi and subi only.
  - cmp 00011 / cmpi 10011: alu_op=1, nz_write=1, reg_write=0.
  - ld 00100 / st 00101: no strobes; go to MEM.
  - Branches (jr/jzr/jnr 01000/01001/01010, j/jz/jn 11000/11001/11010): opcode[4] selects br_src. Low bits select the condition: 00 always, 01 if flag_z, 10 if flag_n. pc_enable=1, pc_src=0 when the branch is taken, else 1. reg_write=0.
  - call 11100 / callr 01100: like j / jr, plus reg_write=1, reg_dst=1, wb_src=010.
- MEM:
  - Drive mem_req=1, mem_sel=0, mem_we=1 for st.
  - On mem_ready: ld asserts reg_write=1 with wb_src=000. Both ld and st assert pc_enable=1, pc_src=1, then go to FETCH.
- Timeout: a wait counter clears on entry to FETCH and MEM. If it reaches TIMEOUT_CYCLES-1 without mem_ready: bus_error=1, go to HALT. mem_ready in that same cycle wins over the timeout.
- HALT: all strobes 0, halted=1. Leave HALT only on reset.
- Static fields (alu_op, alu_src, ext_sel, br_src, wb_src, reg_dst) are valid in EXEC and MEM and are 0 elsewhere; never X.
- Latency: ALU ops and branches take 3 cycles plus fetch wait; ld/st take 4 cycles plus both waits.
- run is sampled only in IDLE.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the opcode enum (all codes above);
  - the wb_src localparams;
  - the br_cond enum;
  - the state enum {IDLE, FETCH, DECODE, EXEC, MEM, HALT}.
- Sub-module cpu_op_table: combinational opcode to {class, static fields, br_cond, legal}. The FSM gates the strobes.

Test Plan:
- Reset, run=1; fetch returns add (00001) with mem_ready after 2 wait cycles -> ir_load at cycle 4; reg_write=1, nz_write=1, wb_src=001 in EXEC; next mem_req with mem_sel=1.
- ld then st, mem_ready immediate -> ld: MEM mem_sel=0, mem_we=0, reg_write=1, wb_src=000; st: mem_we=1, reg_write=0; pc_enable exactly once each.
- jz with flag_z=0 -> pc_src=1; with flag_z=1 -> pc_src=0, br_src=1; jnr with flag_n=1 -> pc_src=0, br_src=0; reg_write=0 in all cases.
- callr 01100 -> reg_write=1, reg_dst=1, wb_src=010, pc_src=0 in the same cycle.
- mem_ready never asserted in MEM, TIMEOUT_CYCLES=16 -> bus_error=1 and halted=1 after 16 MEM cycles; all strobes stay 0 until reset.
- Opcode 00111 -> HALT with HALT_ON_ILLEGAL=1. Reset asserted mid-FETCH -> mem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle CPU controller: opcodes, write-back selects,
// branch conditions, FSM states and the decoded-opcode record.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_MV    = 5'b00000,
    OP_ADD   = 5'b00001,
    OP_SUB   = 5'b00010,
    OP_CMP   = 5'b00011,
    OP_LD    = 5'b00100,
    OP_ST    = 5'b00101,
    OP_JR    = 5'b01000,
    OP_JZR   = 5'b01001,
    OP_JNR   = 5'b01010,
    OP_CALLR = 5'b01100,
    OP_MVI   = 5'b10000,
    OP_ADDI  = 5'b10001,
    OP_SUBI  = 5'b10010,
    OP_CMPI  = 5'b10011,
    OP_MVHI  = 5'b10110,
    OP_J     = 5'b11000,
    OP_JZ    = 5'b11001,
    OP_JN    = 5'b11010,
    OP_CALL  = 5'b11100
  } opcode_e;

  localparam logic [2:0] WB_MEM    = 3'b000;
  localparam logic [2:0] WB_ALU    = 3'b001;
  localparam logic [2:0] WB_PC2    = 3'b010;
  localparam logic [2:0] WB_RY     = 3'b011;
  localparam logic [2:0] WB_IMM8   = 3'b100;
  localparam logic [2:0] WB_IMM8_H = 3'b101;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_N      = 2'b10,
    BR_NEVER  = 2'b11
  } br_cond_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_CMP,
    CL_MEM,
    CL_BR,
    CL_ILL
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic       alu_op;
    logic       alu_src;
    logic       ext_sel;
    logic       br_src;
    logic       reg_dst;
    logic       reg_write;
    logic       nz_write;
    logic       is_store;
    logic [2:0] wb_src;
    br_cond_e   br_cond;
    logic       legal;
  } op_info_t;

endpackage

// File: rtl/cpu_op_table.sv
// Combinational opcode decode: instruction class, static datapath selects,
// branch condition and legality. Strobes are gated by the FSM, not here.
module cpu_op_table
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op,
  input  logic       upper_zero,
  output op_info_t   info
);

  always_comb begin
    info         = '0;
    info.cls     = CL_ILL;
    info.br_cond = BR_NEVER;
    if (upper_zero) begin
      case (op)
        OP_MV:   begin info.cls = CL_ALU; info.reg_write = 1'b1; info.wb_src = WB_RY; end
        OP_ADD:  begin info.cls = CL_ALU; info.reg_write = 1'b1; info.nz_write = 1'b1; info.wb_src = WB_ALU; end
        OP_SUB:  begin info.cls = CL_ALU; info.reg_write = 1'b1; info.nz_write = 1'b1; info.wb_src = WB_ALU;
                       info.alu_op = 1'b1; end
        OP_MVI:  begin info.cls = CL_ALU; info.reg_write = 1'b1; info.wb_src = WB_IMM8; end
        OP_ADDI: begin info.cls = CL_ALU; info.reg_write = 1'b1; info.nz_write = 1'b1; info.wb_src = WB_ALU;
                       info.alu_src = 1'b1; end
        OP_SUBI: begin info.cls = CL_ALU; info.reg_write = 1'b1; info.nz_write = 1'b1; info.wb_src = WB_ALU;
                       info.alu_src = 1'b1; info.alu_op = 1'b1; end
        OP_MVHI: begin info.cls = CL_ALU; info.reg_write = 1'b1; info.wb_src = WB_IMM8_H; end
        OP_CMP:  begin info.cls = CL_CMP; info.nz_write = 1'b1; info.alu_op = 1'b1; end
        OP_CMPI: begin info.cls = CL_CMP; info.nz_write = 1'b1; info.alu_op = 1'b1; info.alu_src = 1'b1; end
        OP_LD:   begin info.cls = CL_MEM; info.reg_write = 1'b1; info.wb_src = WB_MEM; end
        OP_ST:   begin info.cls = CL_MEM; info.is_store = 1'b1; end
        // opcode[4] picks pc-relative target with the wide immediate
        OP_JR, OP_JZR, OP_JNR, OP_J, OP_JZ, OP_JN: begin
          info.cls     = CL_BR;
          info.br_src  = op[4];
          info.ext_sel = op[4];
          info.br_cond = br_cond_e'(op[1:0]);
        end
        OP_CALLR, OP_CALL: begin
          info.cls       = CL_BR;
          info.br_src    = op[4];
          info.ext_sel   = op[4];
          info.br_cond   = BR_ALWAYS;
          info.reg_write = 1'b1;
          info.reg_dst   = 1'b1;
          info.wb_src    = WB_PC2;
        end
        default: ;
      endcase
    end
    info.legal = (info.cls != CL_ILL);
  end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory sequencing over a shared
// memory with ready handshake, wait timeout and illegal-opcode halt.
module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W        = 5,
  parameter int WB_SEL_W        = 3,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_n,
  input  logic                flag_z,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_sel,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                pc_src,
  output logic                br_src,
  output logic                ext_sel,
  output logic                alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic [WB_SEL_W-1:0] wb_src,
  output logic                nz_write,
  output logic                halted,
  output logic                bus_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_error_q, bus_error_d;

  logic [4:0] op5;
  logic       upper_zero;
  op_info_t   info;
  logic       mem_wait;
  logic       timeout_hit;
  logic       taken;

  assign op5 = opcode[4:0];

  if (OPCODE_W > 5) begin : g_wide_op
    assign upper_zero = ~|opcode[OPCODE_W-1:5];
  end else begin : g_plain_op
    assign upper_zero = 1'b1;
  end

  cpu_op_table u_op_table (
    .op         (op5),
    .upper_zero (upper_zero),
    .info       (info)
  );

  assign mem_wait    = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_wait && (wait_cnt_q == CNT_LAST);

  always_comb begin
    case (info.br_cond)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flag_z;
      BR_N:      taken = flag_n;
      default:   taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q | timeout_hit;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
              else if (timeout_hit) state_d = HALT;
      DECODE: if (info.legal) state_d = EXEC;
              else if (HALT_ON_ILLEGAL != 0) state_d = HALT;
              else state_d = FETCH;
      EXEC:   state_d = (info.cls == CL_MEM) ? MEM : FETCH;
      MEM:    if (mem_ready) state_d = FETCH;
              else if (timeout_hit) state_d = HALT;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
    // counts only while stalled in place; any entry into FETCH/MEM starts from zero
    wait_cnt_d = (mem_wait && (state_d == state_q)) ? wait_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_load   = 1'b0;
    pc_enable = 1'b0;
    pc_src    = 1'b0;
    br_src    = 1'b0;
    ext_sel   = 1'b0;
    alu_op    = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = '0;
    nz_write  = 1'b0;
    if ((state_q == EXEC) || (state_q == MEM)) begin
      br_src  = info.br_src;
      ext_sel = info.ext_sel;
      alu_op  = info.alu_op;
      alu_src = info.alu_src;
      reg_dst = info.reg_dst;
      wb_src  = WB_SEL_W'(info.wb_src);
    end
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        ir_load = mem_ready;
      end
      DECODE: begin
        if (!info.legal && (HALT_ON_ILLEGAL == 0)) begin
          pc_enable = 1'b1;
          pc_src    = 1'b1;
        end
      end
      EXEC: begin
        case (info.cls)
          CL_ALU: begin
            reg_write = info.reg_write;
            nz_write  = info.nz_write;
            pc_enable = 1'b1;
            pc_src    = 1'b1;
          end
          CL_CMP: begin
            nz_write  = 1'b1;
            pc_enable = 1'b1;
            pc_src    = 1'b1;
          end
          CL_BR: begin
            reg_write = info.reg_write;
            pc_enable = 1'b1;
            pc_src    = !taken;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = info.is_store;
        if (mem_ready) begin
          reg_write = !info.is_store;
          pc_enable = 1'b1;
          pc_src    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign halted    = (state_q == HALT);
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed bench for cpu_multicycle_ctrl: a table of single-instruction EXEC
// vectors plus hand sequences for memory ops, timeout, illegal opcode and reset.
module tb_cpu_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [4:0] opcode;
  logic       flag_n, flag_z, mem_ready;
  logic       mem_req, mem_we, mem_sel, ir_load, pc_enable, pc_src, br_src, ext_sel;
  logic       alu_op, alu_src, reg_write, reg_dst, nz_write, halted, bus_error;
  logic [2:0] wb_src;

  int total = 0;
  int bad   = 0;
  int pc_en_cnt = 0;
  int cnt0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        fn;
    logic        fz;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  cpu_multicycle_ctrl dut (
    .clk       (clk),
    .reset     (rst),
    .run       (run),
    .opcode    (opcode),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .ir_load   (ir_load),
    .pc_enable (pc_enable),
    .pc_src    (pc_src),
    .br_src    (br_src),
    .ext_sel   (ext_sel),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .nz_write  (nz_write),
    .halted    (halted),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && pc_enable) pc_en_cnt <= pc_en_cnt + 1;

  // {mem_req,mem_we,mem_sel,ir_load,pc_enable,pc_src,br_src,ext_sel,alu_op,alu_src,reg_write,reg_dst,wb_src[2:0],nz_write,halted,bus_error}
  function automatic logic [17:0] outs();
    return {mem_req, mem_we, mem_sel, ir_load, pc_enable, pc_src, br_src, ext_sel,
            alu_op, alu_src, reg_write, reg_dst, wb_src, nz_write, halted, bus_error};
  endfunction

  function automatic logic [17:0] ex(input logic pe, ps, brs, ext, aop, asrc, rw, rdst,
                                     input logic [2:0] wb, input logic nz);
    return {4'b0000, pe, ps, brs, ext, aop, asrc, rw, rdst, wb, nz, 2'b00};
  endfunction

  localparam logic [17:0] FETCH_WAIT = {4'b1010, 14'b0};
  localparam logic [17:0] FETCH_RDY  = {4'b1011, 14'b0};
  localparam logic [17:0] MREQ       = {2'b10, 16'b0};
  localparam logic [17:0] MREQ_WE    = {2'b11, 16'b0};
  localparam logic [17:0] HALT_V     = 18'd2;
  localparam logic [17:0] HALT_BERR  = 18'd3;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] op, input logic fn, input logic fz,
                         input logic [17:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.fz = fz; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 5'b0; flag_n = 1'b0; flag_z = 1'b0;
    @(negedge clk); #2;
    check("reset_outs", outs(), 18'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Enter IDLE with run=1 for one cycle; the following posedge moves to FETCH.
  task automatic idle_run();
    @(posedge clk); #1 run = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), 18'd0);
  endtask

  // Called in the cycle before FETCH; returns sampled in the cycle after DECODE.
  task automatic do_fetch(input logic [4:0] op, input int waits, input logic fn, input logic fz);
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      check("fetch_wait", outs(), FETCH_WAIT);
    end
    @(posedge clk); #1 mem_ready = 1'b1; opcode = op; flag_n = fn; flag_z = fz;
    @(negedge clk);
    check("fetch_ready", outs(), FETCH_RDY);
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check("decode", outs(), 18'd0);
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic mem_cycle(input logic rdy);
    @(posedge clk); #1 mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    add_vec("add",       5'b00001, 0, 0, ex(1,1,0,0,0,0,1,0,3'b001,1));
    add_vec("sub",       5'b00010, 0, 0, ex(1,1,0,0,1,0,1,0,3'b001,1));
    add_vec("mv",        5'b00000, 0, 0, ex(1,1,0,0,0,0,1,0,3'b011,0));
    add_vec("mvi",       5'b10000, 0, 0, ex(1,1,0,0,0,0,1,0,3'b100,0));
    add_vec("addi",      5'b10001, 0, 0, ex(1,1,0,0,0,1,1,0,3'b001,1));
    add_vec("subi",      5'b10010, 0, 0, ex(1,1,0,0,1,1,1,0,3'b001,1));
    add_vec("mvhi",      5'b10110, 0, 0, ex(1,1,0,0,0,0,1,0,3'b101,0));
    add_vec("cmp",       5'b00011, 0, 0, ex(1,1,0,0,1,0,0,0,3'b000,1));
    add_vec("cmpi",      5'b10011, 0, 0, ex(1,1,0,0,1,1,0,0,3'b000,1));
    add_vec("jz_nt",     5'b11001, 0, 0, ex(1,1,1,1,0,0,0,0,3'b000,0));
    add_vec("jz_t",      5'b11001, 0, 1, ex(1,0,1,1,0,0,0,0,3'b000,0));
    add_vec("jnr_t",     5'b01010, 1, 0, ex(1,0,0,0,0,0,0,0,3'b000,0));
    add_vec("jnr_nt",    5'b01010, 0, 1, ex(1,1,0,0,0,0,0,0,3'b000,0));
    add_vec("jzr_t",     5'b01001, 0, 1, ex(1,0,0,0,0,0,0,0,3'b000,0));
    add_vec("j",         5'b11000, 0, 0, ex(1,0,1,1,0,0,0,0,3'b000,0));
    add_vec("jr",        5'b01000, 1, 1, ex(1,0,0,0,0,0,0,0,3'b000,0));
    add_vec("jn_t",      5'b11010, 1, 0, ex(1,0,1,1,0,0,0,0,3'b000,0));
    add_vec("callr",     5'b01100, 0, 0, ex(1,0,0,0,0,0,1,1,3'b010,0));
    add_vec("call",      5'b11100, 0, 0, ex(1,0,1,1,0,0,1,1,3'b010,0));

    // add with two fetch wait cycles straight out of reset
    do_reset();
    idle_run();
    do_fetch(5'b00001, 2, 0, 0);
    check("add_exec", outs(), ex(1,1,0,0,0,0,1,0,3'b001,1));

    // ld then st, each with a single pc_enable
    do_fetch(5'b00100, 0, 0, 0);
    cnt0 = pc_en_cnt;
    check("ld_exec", outs(), 18'd0);
    mem_cycle(1'b1);
    check("ld_mem", outs(), ex(1,1,0,0,0,0,1,0,3'b000,0) | MREQ);
    do_fetch(5'b00101, 0, 0, 0);
    check_int("ld_pc_en", pc_en_cnt - cnt0, 1);
    cnt0 = pc_en_cnt;
    check("st_exec", outs(), 18'd0);
    mem_cycle(1'b0);
    check("st_mem_wait", outs(), MREQ_WE);
    mem_cycle(1'b1);
    check("st_mem", outs(), ex(1,1,0,0,0,0,0,0,3'b000,0) | MREQ_WE);
    do_fetch(5'b00001, 1, 0, 0);
    check_int("st_pc_en", pc_en_cnt - cnt0, 1);
    check("add_after_st", outs(), ex(1,1,0,0,0,0,1,0,3'b001,1));

    foreach (vecs[i]) begin
      do_fetch(vecs[i].op, i % 3, vecs[i].fn, vecs[i].fz);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // MEM never ready: 16 requesting cycles, then sticky bus error and halt
    do_fetch(5'b00100, 0, 0, 0);
    check("ld_exec_to", outs(), 18'd0);
    for (int k = 1; k <= 16; k++) begin
      mem_cycle(1'b0);
      check($sformatf("mem_wait_%0d", k), outs(), MREQ);
    end
    mem_cycle(1'b0);
    check("timeout_halt", outs(), HALT_BERR);
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_cycle(1'b1);
      check("halt_hold", outs(), HALT_BERR);
    end

    // ready on the last allowed cycle completes normally
    do_reset();
    idle_run();
    do_fetch(5'b00100, 0, 0, 0);
    for (int k = 1; k <= 15; k++) mem_cycle(1'b0);
    mem_cycle(1'b1);
    check("ready_wins", outs(), ex(1,1,0,0,0,0,1,0,3'b000,0) | MREQ);
    do_fetch(5'b00001, 0, 0, 0);
    check("no_bus_err", outs(), ex(1,1,0,0,0,0,1,0,3'b001,1));

    // illegal opcode halts
    do_fetch(5'b00111, 1, 0, 0);
    check("illegal_halt", outs(), HALT_V);
    for (int k = 0; k < 2; k++) begin
      mem_cycle(1'b1);
      check("illegal_hold", outs(), HALT_V);
    end

    // reset in the middle of a fetch drops the request at once
    do_reset();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check("midfetch_req", outs(), FETCH_WAIT);
    #2 rst = 1'b1;
    #1 check("async_rst", outs(), 18'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_no_run", outs(), 18'd0);
    run = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("restart_fetch", outs(), FETCH_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
